// File: rtl/fft_r2sdf_bf_stage.sv
// -----------------------------------------------------------------------------
// fft_r2sdf_bf_stage
//   Radix-2 single-path delay-feedback butterfly stage for a pipelined SDF FFT.
//   The first DELAY_LEN samples of a frame (phase 0) go into the feedback delay
//   line. The next DELAY_LEN samples (phase 1) are combined with the delayed
//   samples. Sums are sent out at once. Differences go back into the delay line
//   and drain out during phase 0 of the next frame.
//
// Ports
//   clk_i    : clock, rising edge
//   rst_i    : asynchronous active-high reset
//   valid_i  : input sample valid; the stage advances only when high
//   sync_i   : qualified by valid_i; marks sample index 0 of a frame
//   x_re_i   : signed real input, DATA_WIDTH bits
//   x_im_i   : signed imaginary input, DATA_WIDTH bits
//   valid_o  : output sample valid (registered)
//   sync_o   : first output sample of a frame (registered)
//   z_re_o   : signed real output, OUT_WIDTH bits
//   z_im_o   : signed imaginary output, OUT_WIDTH bits
// -----------------------------------------------------------------------------
module fft_r2sdf_bf_stage #(
    parameter int DATA_WIDTH = 25,
    parameter int DELAY_LEN  = 512,
    parameter int SCALE      = 0,
    parameter int OUT_WIDTH  = DATA_WIDTH + 1 - SCALE
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        valid_i,
    input  logic                        sync_i,
    input  logic signed [DATA_WIDTH-1:0] x_re_i,
    input  logic signed [DATA_WIDTH-1:0] x_im_i,
    output logic                        valid_o,
    output logic                        sync_o,
    output logic signed [OUT_WIDTH-1:0] z_re_o,
    output logic signed [OUT_WIDTH-1:0] z_im_o
);

    localparam int W     = DATA_WIDTH + 1;
    localparam int LOG2D = $clog2(DELAY_LEN);
    localparam int CW    = LOG2D + 1;
    localparam int AW    = (LOG2D > 0) ? LOG2D : 1;

    logic [CW-1:0]        r_cnt;
    logic                 r_primed;
    logic                 r_synced;
    logic [AW-1:0]        r_wptr;
    logic signed [W-1:0]  r_dl_re [DELAY_LEN];
    logic signed [W-1:0]  r_dl_im [DELAY_LEN];

    logic [CW-1:0]        w_idx;
    logic                 w_phase;
    logic                 w_resync;
    logic                 w_primed_next;
    logic                 w_synced_next;
    logic signed [W-1:0]  w_x_re, w_x_im;
    logic signed [W-1:0]  w_head_re, w_head_im;
    logic signed [W-1:0]  w_s_re, w_s_im;
    logic signed [W-1:0]  w_din_re, w_din_im;
    logic signed [OUT_WIDTH-1:0] w_z_re, w_z_im;

    // A sync forces this sample to index 0. The counter then holds the
    // index expected for the next sample.
    assign w_idx    = sync_i ? '0 : r_cnt;
    assign w_phase  = w_idx[CW-1];
    assign w_resync = valid_i & sync_i & (r_cnt != '0);
    assign w_synced_next = r_synced | (valid_i & sync_i);

    assign w_x_re = {x_re_i[DATA_WIDTH-1], x_re_i};
    assign w_x_im = {x_im_i[DATA_WIDTH-1], x_im_i};

    // The write pointer advances on every accepted sample. The slot it points
    // at therefore holds the sample written DELAY_LEN accepted samples earlier.
    assign w_head_re = r_dl_re[r_wptr];
    assign w_head_im = r_dl_im[r_wptr];

    always_comb begin
        // NOTE: every output of a combinational block gets a default first, so no path leaves a latch behind.
        w_s_re   = w_head_re;
        w_s_im   = w_head_im;
        w_din_re = w_x_re;
        w_din_im = w_x_im;
        if (w_phase) begin
            w_s_re   = w_head_re + w_x_re;
            w_s_im   = w_head_im + w_x_im;
            w_din_re = w_head_re - w_x_re;
            w_din_im = w_head_im - w_x_im;
        end
    end

    // A misaligned sync drops primed. Stale delay-line contents therefore
    // never reach the output as valid data. The first phase-1 sample after
    // any sync re-arms primed.
    always_comb begin
        w_primed_next = r_primed;
        if (valid_i) begin
            if (w_resync) begin
                w_primed_next = 1'b0;
            end else if (w_phase && w_synced_next) begin
                w_primed_next = 1'b1;
            end
        end
    end

    generate
        if (SCALE != 0) begin : g_scale
            // Round half up: add one at W+1 bits, then drop the LSB.
            logic signed [W:0] w_rnd_re, w_rnd_im;
            assign w_rnd_re = {w_s_re[W-1], w_s_re} + (W+1)'(1);
            assign w_rnd_im = {w_s_im[W-1], w_s_im} + (W+1)'(1);
            assign w_z_re   = w_rnd_re[OUT_WIDTH:1];
            assign w_z_im   = w_rnd_im[OUT_WIDTH:1];
        end else begin : g_full
            assign w_z_re = w_s_re;
            assign w_z_im = w_s_im;
        end
    endgenerate

    // NOTE: the delay line has no reset, so it can map onto RAM. Stale data is gated by primed instead.
    always_ff @(posedge clk_i) begin
        if (valid_i) begin
            r_dl_re[r_wptr] <= w_din_re;
            r_dl_im[r_wptr] <= w_din_im;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_cnt    <= '0;
            r_primed <= 1'b0;
            r_synced <= 1'b0;
            r_wptr   <= '0;
            valid_o  <= 1'b0;
            sync_o   <= 1'b0;
            z_re_o   <= '0;
            z_im_o   <= '0;
        end else begin
            // NOTE: state registers use non-blocking assignments, so every register samples pre-edge values.
            valid_o  <= valid_i & w_primed_next;
            sync_o   <= valid_i & w_primed_next & (w_idx == CW'(DELAY_LEN));
            if (valid_i) begin
                r_cnt    <= w_idx + CW'(1);
                r_primed <= w_primed_next;
                r_synced <= w_synced_next;
                r_wptr   <= (r_wptr == AW'(DELAY_LEN - 1)) ? '0 : r_wptr + AW'(1);
                z_re_o   <= w_z_re;
                z_im_o   <= w_z_im;
            end
        end
    end

endmodule

// File: tb/tb_fft_r2sdf_bf_stage.sv
// -----------------------------------------------------------------------------
// tb_fft_r2sdf_bf_stage
//   Drives two stages in parallel with the same stimulus. Both use DATA_WIDTH=8
//   and DELAY_LEN=4. One has SCALE=0 (9-bit outputs), the other SCALE=1 (8-bit
//   outputs). The stimulus pushes the expected outputs into one queue per
//   stage. One monitor per stage pops and compares on each valid output.
// -----------------------------------------------------------------------------
module tb_fft_r2sdf_bf_stage;

    localparam int DW = 8;
    localparam int D  = 4;

    typedef struct {
        int re;
        int im;
        bit sy;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic valid_i = 1'b0;
    logic sync_i = 1'b0;
    logic signed [DW-1:0] x_re = '0;
    logic signed [DW-1:0] x_im = '0;

    logic                 v0, s0, v1, s1;
    logic signed [DW:0]   z0_re, z0_im;
    logic signed [DW-1:0] z1_re, z1_im;

    exp_t q0[$];
    exp_t q1[$];
    int   n_cmp = 0;
    int   n_err = 0;
    bit   prev_vi = 1'b0;

    // Frame-level reference state: current frame, previous differences.
    int  fr_re[2*D], fr_im[2*D];
    int  pd_re[D],   pd_im[D];
    int  b_idx = 0;
    bit  have_diff = 1'b0;

    int  fre[2*D], fim[2*D];

    always #5 clk = ~clk;

    fft_r2sdf_bf_stage #(.DATA_WIDTH(DW), .DELAY_LEN(D), .SCALE(0)) u_full (
        .clk_i(clk), .rst_i(rst), .valid_i(valid_i), .sync_i(sync_i),
        .x_re_i(x_re), .x_im_i(x_im),
        .valid_o(v0), .sync_o(s0), .z_re_o(z0_re), .z_im_o(z0_im)
    );

    fft_r2sdf_bf_stage #(.DATA_WIDTH(DW), .DELAY_LEN(D), .SCALE(1)) u_half (
        .clk_i(clk), .rst_i(rst), .valid_i(valid_i), .sync_i(sync_i),
        .x_re_i(x_re), .x_im_i(x_im),
        .valid_o(v1), .sync_o(s1), .z_re_o(z1_re), .z_im_o(z1_im)
    );

    function automatic int half(input int s);
        return (s + 1) >>> 1;
    endfunction

    task automatic push(input int re, input int im, input bit sy);
        exp_t e;
        e.re = re; e.im = im; e.sy = sy;
        q0.push_back(e);
        e.re = half(re); e.im = half(im);
        q1.push_back(e);
    endtask

    task automatic check(input string name, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    // Issue one accepted sample and record what the stage must emit for it.
    task automatic send(input int re, input int im, input bit sy);
        int i;
        if (sy) begin
            if (b_idx != 0) have_diff = 1'b0;
            b_idx = 0;
        end
        i = b_idx;
        if (i < D) begin
            fr_re[i] = re; fr_im[i] = im;
            if (have_diff) push(pd_re[i], pd_im[i], 1'b0);
        end else begin
            push(fr_re[i-D] + re, fr_im[i-D] + im, i == D);
            pd_re[i-D] = fr_re[i-D] - re;
            pd_im[i-D] = fr_im[i-D] - im;
            if (i == 2*D-1) have_diff = 1'b1;
        end
        b_idx = (i + 1) % (2*D);
        valid_i = 1'b1; sync_i = sy;
        x_re = DW'(re); x_im = DW'(im);
        @(posedge clk); #1;
        valid_i = 1'b0; sync_i = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic send_frame(input int gap_max);
        for (int i = 0; i < 2*D; i++) begin
            send(fre[i], fim[i], i == 0);
            if (gap_max > 0) idle($urandom_range(gap_max, 0));
        end
    endtask

    task automatic check_reset_state();
        check("rst_valid_full", int'(v0), 0);
        check("rst_sync_full",  int'(s0), 0);
        check("rst_zre_full",   int'(z0_re), 0);
        check("rst_zim_full",   int'(z0_im), 0);
        check("rst_valid_half", int'(v1), 0);
        check("rst_zre_half",   int'(z1_re), 0);
    endtask

    always @(posedge clk) prev_vi <= valid_i;

    always @(negedge clk) begin
        if (!rst && !prev_vi) begin
            check("valid_after_bubble_full", int'(v0), 0);
            check("valid_after_bubble_half", int'(v1), 0);
        end
        if (v0) begin
            exp_t e;
            n_cmp++;
            if (q0.size() == 0) begin
                n_err++;
                $display("FAIL out_full: unexpected output re=%0d im=%0d, expected none", z0_re, z0_im);
            end else begin
                e = q0.pop_front();
                if (int'(z0_re) != e.re || int'(z0_im) != e.im || s0 != e.sy) begin
                    n_err++;
                    $display("FAIL out_full: got re=%0d im=%0d sync=%0d, expected re=%0d im=%0d sync=%0d",
                             z0_re, z0_im, s0, e.re, e.im, e.sy);
                end
            end
        end
        if (v1) begin
            exp_t e;
            n_cmp++;
            if (q1.size() == 0) begin
                n_err++;
                $display("FAIL out_half: unexpected output re=%0d im=%0d, expected none", z1_re, z1_im);
            end else begin
                e = q1.pop_front();
                if (int'(z1_re) != e.re || int'(z1_im) != e.im || s1 != e.sy) begin
                    n_err++;
                    $display("FAIL out_half: got re=%0d im=%0d sync=%0d, expected re=%0d im=%0d sync=%0d",
                             z1_re, z1_im, s1, e.re, e.im, e.sy);
                end
            end
        end
    end

    initial begin
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check_reset_state();
        @(posedge clk); #1;
        rst = 1'b0;

        // Ramp frames. The first frame gives sums 6,8,10,12; differences are -4.
        fre = '{1, 2, 3, 4, 5, 6, 7, 8};          fim = '{0, 0, 0, 0, 0, 0, 0, 0};
        send_frame(0);
        fre = '{9, 10, 11, 12, 13, 14, 15, 16};   fim = '{1, -1, 2, -2, 3, -3, 4, -4};
        send_frame(0);

        // Extreme inputs: full-growth sums 254 and -256, differences 0.
        fre = '{127, -128, 5, -7, 127, -128, 3, 9};
        fim = '{-128, 127, 0, 1, -128, 127, 2, 3};
        send_frame(0);

        // Rounding cases for the halved stage: 7->4, -7->-3, -1->0, 0->0.
        fre = '{3, -3, -1, 0, 4, -4, 0, 0};       fim = '{3, -3, -1, 0, 4, -4, 0, 0};
        send_frame(0);

        // Ramp frame again with random bubbles between samples.
        fre = '{1, 2, 3, 4, 5, 6, 7, 8};          fim = '{8, 7, 6, 5, 4, 3, 2, 1};
        send_frame(1);
        fre = '{-5, 6, -7, 8, 20, -30, 40, -50};  fim = '{0, 1, 0, 1, 0, 1, 0, 1};
        send_frame(2);

        // Resync: sync arrives where index 2 was expected.
        send(11, 12, 1'b1);
        send(13, 14, 1'b0);
        fre = '{10, 20, 30, 40, 1, 2, 3, 4};      fim = '{-1, -2, -3, -4, 5, 6, 7, 8};
        send_frame(0);
        fre = '{2, 4, 6, 8, 1, 3, 5, 7};          fim = '{0, 0, 0, 0, 1, 1, 1, 1};
        send_frame(0);

        // Reset after index 5, then restart with a fresh synced frame.
        for (int i = 0; i < 6; i++) send(i + 50, -i, i == 0);
        idle(2);
        rst = 1'b1;
        b_idx = 0;
        have_diff = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_state();
        @(posedge clk); #1;
        rst = 1'b0;
        idle(1);
        fre = '{7, -7, 9, -9, 1, 1, -1, -1};      fim = '{3, 3, 3, 3, -3, -3, -3, -3};
        send_frame(0);
        fre = '{0, 0, 0, 0, 0, 0, 0, 0};          fim = '{0, 0, 0, 0, 0, 0, 0, 0};
        send_frame(1);

        idle(4);
        check("leftover_full", q0.size(), 0);
        check("leftover_half", q1.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
